hazard_controller: RTL and testbench
====================================

# hazard_controller

Central pipeline sequencer for the five-stage MIPS datapath. It decides, every cycle, whether the PC and IF/ID register advance and whether IF/ID, ID/EX and EX/MEM load a bubble. It resolves load-use hazards, taken branches/jumps, exceptions and multi-cycle multiply/divide stalls, and keeps a stall-cycle counter for performance analysis. All flush outputs drive the synchronous `flush` inputs of the pipeline registers.

## Interface
- `MD_LATENCY`, 4: total stall cycles for a mult/div in ID. Legal range 2..255.
- `STALL_CNT_W`, 16: width of the stall counter.

- `Clk`  in  1  system clock, rising edge
- `Rst`  in  1  asynchronous, active-high reset
- `IDRs`, `IDRt`  in  5 each  source registers of the instruction in ID
- `IDUsesRt`  in  1  ID instruction reads rt
- `IDMulDiv`  in  1  ID instruction is mult/multu/div/divu
- `EXMemRead`  in  1  instruction in EX (ID/EX outputs) is a load
- `EXRegDst`  in  5  destination register of the EX instruction
- `EXBranchTaken`  in  1  branch/jump resolved taken in EX
- `Exception`  in  1  exception raised in MEM
- `PCWrite`, `IFIDWrite`  out  1 each  stage-advance enables
- `IFIDFlush`, `IDEXFlush`, `EXMEMFlush`  out  1 each  bubble inserts
- `MDStart`  out  1  one-cycle start pulse to the mult/div unit
- `Busy`  out  1  in a multi-cycle stall
- `StallCount`  out  `STALL_CNT_W`  cycles with `PCWrite`=0, saturating

## Operation
- States: RUN, MD_WAIT. The wait counter `cnt` is 8 bits wide.
- Outputs are combinational from state and inputs (Mealy). Defaults: `PCWrite`=`IFIDWrite`=1, all flushes, `MDStart` and `Busy` = 0.
- Load-use condition: `EXMemRead` && `EXRegDst`≠0 && (`EXRegDst`==`IDRs` || (`IDUsesRt` && `EXRegDst`==`IDRt`)).
- In RUN, the first matching rule applies:
  1. `Exception`: flush IF/ID, ID/EX and EX/MEM. `PCWrite`=1 (vector fetch).
  2. `EXBranchTaken`: flush IF/ID and ID/EX. `PCWrite`=1.
  3. Load-use: `PCWrite`=`IFIDWrite`=0. Flush ID/EX. Stay in RUN.
  4. `IDMulDiv`: `MDStart`=1, `PCWrite`=`IFIDWrite`=0, flush ID/EX. Set `cnt`=`MD_LATENCY`-2 and go to MD_WAIT.
- In MD_WAIT: `Busy`=1, `PCWrite`=`IFIDWrite`=0, flush ID/EX.
  - If `cnt`==0, return to RUN. Otherwise decrement `cnt`.
  - `Exception` performs rule 1 (with `PCWrite`=1 and `Busy`=0), aborts the wait and returns to RUN. `MDStart` is not reissued.
  - `EXBranchTaken` is ignored in MD_WAIT, because EX holds a bubble there.
- After a mult/div releases, the ID instruction re-evaluates in RUN. `IDMulDiv` still being high does not restart the unit on the cycle immediately after MD_WAIT exits: an internal `md_done` flag suppresses rule 4 for exactly one cycle.
- `StallCount` increments on every rising edge where `PCWrite`=0 and `Rst`=0. It holds at all-ones.
- While `Rst` is high:
  - State is RUN, `cnt`=0, `md_done`=0, `StallCount`=0.
  - Outputs are forced: `PCWrite`=`IFIDWrite`=0, all three flushes =1, `MDStart`=`Busy`=0.

## Timing
- Load-use: exactly one bubble. The PC and IF/ID hold for 1 cycle.
- Mult/div: `PCWrite` is low for exactly `MD_LATENCY` consecutive cycles (the detection cycle plus `MD_LATENCY`-1 MD_WAIT cycles). `MDStart` is high only in the detection cycle.
- Branch/exception flushes take effect at the next rising edge, the same edge on which the PC loads the target.
- Exception and branch together: the exception wins, so all three registers flush.
- Branch and load-use together: the branch wins and no stall occurs.
- Reset is honoured mid-MD_WAIT: the FSM returns immediately to RUN.

## Structure
- Shared package `hazard_pkg`:
  - state enum (RUN, MD_WAIT)
  - `REG_ADDR_W`=5
  - default `MD_LATENCY`
- Sub-module `load_use_detect`: purely combinational comparator producing the load-use condition, reused by the forwarding unit's tests.

## Test plan
- Load into $t0 in EX while ID reads $t0 as rs → one cycle with `PCWrite`=0 and `IDEXFlush`=1, then normal flow. `StallCount`=1.
- Same as above with `EXRegDst`=0, or with the match only on rt while `IDUsesRt`=0 → no stall.
- `IDMulDiv`=1 with `MD_LATENCY`=4 → `MDStart` pulses once; `PCWrite`=0 for 4 cycles; `Busy`=1 for 3; `StallCount`=4. No restart in the release cycle.
- `EXBranchTaken`=1 in the same cycle as load-use and `IDMulDiv` → `IFIDFlush`=`IDEXFlush`=1, `PCWrite`=1, `MDStart`=0, state stays RUN.
- `Exception` in the 2nd MD_WAIT cycle → all three flushes =1, `PCWrite`=1, RUN on the next edge. Then `Rst` pulsed mid-wait → outputs forced to reset values and `StallCount`=0.
- Force 70000 stall cycles → `StallCount` saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

   // Register specifier width of the MIPS datapath
   localparam int REG_ADDR_W = 5;

   // Width of the mult/div wait counter
   localparam int MD_CNT_W = 8;

   // Default total stall cycles for a mult/div sitting in ID
   localparam int MD_LATENCY_DEFAULT = 4;

   // Sequencer states: normal flow, or waiting on the multi-cycle unit
   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_controller_load_use_detect.sv
// Combinational load-use comparator: the load in EX writes a register
// that the instruction in ID is about to read.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_reg_dst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   output logic                  load_use
);

   // $zero is never a real dependency; rt only matters when ID actually reads it
   always_comb begin
      load_use = ex_mem_read
              && (ex_reg_dst != '0)
              && ((ex_reg_dst == id_rs) || (id_uses_rt && (ex_reg_dst == id_rt)));
   end

endmodule

// File: rtl/hazard_controller.sv
// Central pipeline sequencer: stage-advance enables, bubble inserts,
// mult/div start/wait handling and a saturating stall-cycle counter.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY  = MD_LATENCY_DEFAULT,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [REG_ADDR_W-1:0]  IDRs,
   input  logic [REG_ADDR_W-1:0]  IDRt,
   input  logic                   IDUsesRt,
   input  logic                   IDMulDiv,
   input  logic                   EXMemRead,
   input  logic [REG_ADDR_W-1:0]  EXRegDst,
   input  logic                   EXBranchTaken,
   input  logic                   Exception,
   output logic                   PCWrite,
   output logic                   IFIDWrite,
   output logic                   IFIDFlush,
   output logic                   IDEXFlush,
   output logic                   EXMEMFlush,
   output logic                   MDStart,
   output logic                   Busy,
   output logic [STALL_CNT_W-1:0] StallCount
);

   // The detection cycle is one stall and the final MD_WAIT cycle sees cnt==0,
   // so the wait counter starts two below the total latency.
   localparam logic [MD_CNT_W-1:0] MD_START_CNT = MD_CNT_W'(MD_LATENCY - 2);

   hz_state_e              state_q, state_d;
   logic [MD_CNT_W-1:0]    cnt_q, cnt_d;
   logic                   md_done_q, md_done_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_flush;
   logic ex_mem_flush;
   logic md_start;
   logic busy;

   load_use_detect u_load_use_detect (
      .ex_mem_read (EXMemRead),
      .ex_reg_dst  (EXRegDst),
      .id_rs       (IDRs),
      .id_rt       (IDRt),
      .id_uses_rt  (IDUsesRt),
      .load_use    (load_use)
   );

   // State, wait counter, release flag and stall counter registers
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         md_done_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_done_q   <= md_done_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next state: enter MD_WAIT on a start pulse, leave on count expiry or exception
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_done_d = 1'b0;
      case (state_q)
         RUN: begin
            if (md_start) begin
               state_d = MD_WAIT;
               cnt_d   = MD_START_CNT;
            end
         end
         MD_WAIT: begin
            if (Exception) begin
               // Aborted wait: the ID instruction is flushed, so no restart guard is needed
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               // Normal release: keep the still-present mult/div in ID from restarting
               state_d   = RUN;
               md_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Mealy outputs, highest-priority rule first; reset forces a frozen, fully flushed pipe
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      md_start     = 1'b0;
      busy         = 1'b0;
      if (Rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (Exception) begin
         // Vector fetch: PC loads the handler while everything younger is squashed
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (state_q == MD_WAIT) begin
         // EX holds a bubble here, so a branch indication cannot be genuine
         busy        = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (EXBranchTaken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (IDMulDiv && !md_done_q) begin
         md_start    = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // Stall counter counts every cycle the PC is held and sticks at all-ones
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign PCWrite    = pc_write;
   assign IFIDWrite  = if_id_write;
   assign IFIDFlush  = if_id_flush;
   assign IDEXFlush  = id_ex_flush;
   assign EXMEMFlush = ex_mem_flush;
   assign MDStart    = md_start;
   assign Busy       = busy;
   assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_hazard_controller;

   localparam int MD_LAT = 4;
   localparam int SCW    = 16;
   localparam int SAT    = 65535;

   logic       Clk;
   logic       Rst;
   logic [4:0] IDRs, IDRt, EXRegDst;
   logic       IDUsesRt, IDMulDiv, EXMemRead, EXBranchTaken, Exception;
   logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MDStart, Busy;
   logic [SCW-1:0] StallCount;

   int checks   = 0;
   int failures = 0;

   hazard_controller #(
      .MD_LATENCY  (MD_LAT),
      .STALL_CNT_W (SCW)
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .IDRs          (IDRs),
      .IDRt          (IDRt),
      .IDUsesRt      (IDUsesRt),
      .IDMulDiv      (IDMulDiv),
      .EXMemRead     (EXMemRead),
      .EXRegDst      (EXRegDst),
      .EXBranchTaken (EXBranchTaken),
      .Exception     (Exception),
      .PCWrite       (PCWrite),
      .IFIDWrite     (IFIDWrite),
      .IFIDFlush     (IFIDFlush),
      .IDEXFlush     (IDEXFlush),
      .EXMEMFlush    (EXMEMFlush),
      .MDStart       (MDStart),
      .Busy          (Busy),
      .StallCount    (StallCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic pc;
      logic ifidw;
      logic ifidf;
      logic idexf;
      logic exmemf;
      logic mds;
      logic busy;
   } exp_t;

   int md_left   = 0;   // mult/div wait cycles still to come after the current one
   bit skip_md   = 0;   // first cycle after a normal mult/div release
   int stall_exp = 0;

   function automatic exp_t model_out();
      exp_t e;
      bit   lu;
      lu = EXMemRead && (EXRegDst != 5'd0)
           && ((EXRegDst == IDRs) || (IDUsesRt && (EXRegDst == IDRt)));
      e = '{pc: 1'b1, ifidw: 1'b1, default: 1'b0};
      if (Rst) begin
         e = '{pc: 1'b0, ifidw: 1'b0, ifidf: 1'b1, idexf: 1'b1, exmemf: 1'b1, default: 1'b0};
      end else if (Exception) begin
         e.ifidf = 1'b1; e.idexf = 1'b1; e.exmemf = 1'b1;
      end else if (md_left > 0) begin
         e.busy = 1'b1; e.pc = 1'b0; e.ifidw = 1'b0; e.idexf = 1'b1;
      end else if (EXBranchTaken) begin
         e.ifidf = 1'b1; e.idexf = 1'b1;
      end else if (lu) begin
         e.pc = 1'b0; e.ifidw = 1'b0; e.idexf = 1'b1;
      end else if (IDMulDiv && !skip_md) begin
         e.mds = 1'b1; e.pc = 1'b0; e.ifidw = 1'b0; e.idexf = 1'b1;
      end
      return e;
   endfunction

   // Advance the model on each rising edge using the inputs of the ending cycle
   always @(posedge Clk) begin
      exp_t e;
      e = model_out();
      if (Rst) begin
         md_left   = 0;
         skip_md   = 0;
         stall_exp = 0;
      end else begin
         if (!e.pc && stall_exp < SAT) stall_exp = stall_exp + 1;
         if (md_left > 0) begin
            if (Exception) begin
               md_left = 0;
               skip_md = 0;
            end else begin
               md_left = md_left - 1;
               skip_md = (md_left == 0);
            end
         end else begin
            skip_md = 0;
            if (e.mds) md_left = MD_LAT - 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   // Compare every output against the model on each falling edge
   always @(negedge Clk) begin
      exp_t e;
      e = model_out();
      chk("PCWrite",    int'(PCWrite),    int'(e.pc));
      chk("IFIDWrite",  int'(IFIDWrite),  int'(e.ifidw));
      chk("IFIDFlush",  int'(IFIDFlush),  int'(e.ifidf));
      chk("IDEXFlush",  int'(IDEXFlush),  int'(e.idexf));
      chk("EXMEMFlush", int'(EXMEMFlush), int'(e.exmemf));
      chk("MDStart",    int'(MDStart),    int'(e.mds));
      chk("Busy",       int'(Busy),       int'(e.busy));
      chk("StallCount", int'(StallCount), Rst ? 0 : stall_exp);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_in();
      IDRs = 5'd0; IDRt = 5'd0; EXRegDst = 5'd0;
      IDUsesRt = 1'b0; IDMulDiv = 1'b0; EXMemRead = 1'b0;
      EXBranchTaken = 1'b0; Exception = 1'b0;
   endtask

   initial begin
      int md_pulses;
      int busy_cyc;
      int pc_low;
      Rst = 1'b1;
      clear_in();
      tick(); tick();
      @(negedge Clk);
      chk("lit_reset_pcwrite", int'(PCWrite), 0);
      chk("lit_reset_exmemflush", int'(EXMEMFlush), 1);
      chk("lit_reset_stallcount", int'(StallCount), 0);
      tick();
      Rst = 1'b0;
      tick();

      // Load-use on rs: exactly one bubble
      EXMemRead = 1'b1; EXRegDst = 5'd8; IDRs = 5'd8; IDRt = 5'd9; IDUsesRt = 1'b1;
      @(negedge Clk);
      chk("lit_lu_pcwrite", int'(PCWrite), 0);
      chk("lit_lu_idexflush", int'(IDEXFlush), 1);
      tick();
      clear_in();
      @(negedge Clk);
      chk("lit_lu_release", int'(PCWrite), 1);
      chk("lit_lu_stallcount", int'(StallCount), 1);
      tick();

      // No stall: destination $zero, and rt-only match while rt unused
      EXMemRead = 1'b1; EXRegDst = 5'd0; IDRs = 5'd0;
      @(negedge Clk);
      chk("lit_zero_dst", int'(PCWrite), 1);
      tick();
      EXRegDst = 5'd10; IDRs = 5'd3; IDRt = 5'd10; IDUsesRt = 1'b0;
      @(negedge Clk);
      chk("lit_rt_unused", int'(PCWrite), 1);
      tick();
      IDUsesRt = 1'b1;
      @(negedge Clk);
      chk("lit_rt_used", int'(PCWrite), 0);
      tick();
      clear_in();
      tick();

      // Mult/div: 4 stall cycles, one start pulse, 3 busy, no restart at release
      IDMulDiv = 1'b1;
      md_pulses = 0; busy_cyc = 0; pc_low = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         md_pulses += int'(MDStart);
         busy_cyc  += int'(Busy);
         pc_low    += int'(!PCWrite);
         tick();
      end
      IDMulDiv = 1'b0;
      chk("lit_md_pulses", md_pulses, 1);
      chk("lit_md_busy", busy_cyc, 3);
      chk("lit_md_pclow", pc_low, 4);
      @(negedge Clk);
      chk("lit_md_stallcount", int'(StallCount), 6);
      tick();

      // Branch beats load-use and mult/div in the same cycle
      EXBranchTaken = 1'b1; EXMemRead = 1'b1; EXRegDst = 5'd9; IDRs = 5'd9; IDMulDiv = 1'b1;
      @(negedge Clk);
      chk("lit_br_ifidflush", int'(IFIDFlush), 1);
      chk("lit_br_idexflush", int'(IDEXFlush), 1);
      chk("lit_br_exmemflush", int'(EXMEMFlush), 0);
      chk("lit_br_pcwrite", int'(PCWrite), 1);
      chk("lit_br_mdstart", int'(MDStart), 0);
      tick();
      clear_in();
      @(negedge Clk);
      chk("lit_br_staysrun", int'(Busy), 0);
      tick();

      // Exception in the second MD_WAIT cycle aborts the wait
      IDMulDiv = 1'b1;
      tick();
      tick();
      Exception = 1'b1;
      @(negedge Clk);
      chk("lit_exc_ifidflush", int'(IFIDFlush), 1);
      chk("lit_exc_exmemflush", int'(EXMEMFlush), 1);
      chk("lit_exc_pcwrite", int'(PCWrite), 1);
      chk("lit_exc_busy", int'(Busy), 0);
      tick();
      clear_in();
      @(negedge Clk);
      chk("lit_exc_run_pc", int'(PCWrite), 1);
      chk("lit_exc_stallcount", int'(StallCount), 8);
      tick();

      // Reset asserted mid-wait
      IDMulDiv = 1'b1;
      tick();
      tick();
      Rst = 1'b1;
      @(negedge Clk);
      chk("lit_rst_pcwrite", int'(PCWrite), 0);
      chk("lit_rst_idexflush", int'(IDEXFlush), 1);
      chk("lit_rst_busy", int'(Busy), 0);
      chk("lit_rst_stallcount", int'(StallCount), 0);
      clear_in();
      tick(); tick();
      Rst = 1'b0;
      @(negedge Clk);
      chk("lit_rst_release_pc", int'(PCWrite), 1);
      tick();

      // Saturation: hold a load-use stall for 70000 cycles
      EXMemRead = 1'b1; EXRegDst = 5'd5; IDRs = 5'd5;
      repeat (70000) tick();
      @(negedge Clk);
      chk("lit_sat_stallcount", int'(StallCount), SAT);
      tick();
      clear_in();
      tick();
      @(negedge Clk);
      chk("lit_sat_hold", int'(StallCount), SAT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
